ycbcr2rgb: RTL and testbench



---
 rtl/ycbcr2rgb.sv | 139 +++++++++++++
 tb/tb_ycbcr2rgb.sv | 138 +++++++++++++
 2 files changed

// File: rtl/ycbcr2rgb.sv
// ycbcr2rgb: full-range BT.601 (JPEG) YCbCr to 24-bit RGB converter.
//
// This is a free-running 4-stage pipeline.
// The sync and data-enable signals travel alongside the pixel data,
// so output timing matches input timing exactly, delayed by 4 cycles.
//
// Ports:
//   clk        pixel clock, rising edge
//   rst        asynchronous, active-high reset
//   hsync_in   horizontal sync in
//   vsync_in   vertical sync in
//   de_in      data enable in
//   pixel_in   {Y, Cb, Cr}, 8 bits each, unsigned
//   hsync_out  hsync_in delayed 4 cycles
//   vsync_out  vsync_in delayed 4 cycles
//   de_out     de_in delayed 4 cycles
//   pixel_out  {R, G, B}, forced to zero whenever de_out is low
//
// Build option:
//   YCBCR2RGB_CLAMP_EN  when defined, saturate each channel to 0..255.
//                       Otherwise take the low 8 bits (modulo-256 wrap).

module ycbcr2rgb (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        de_in,
    input  logic [23:0] pixel_in,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        de_out,
    output logic [23:0] pixel_out
);

    // Q.14 coefficients
    localparam logic signed [25:0] CoefRv = 26'sd22970;
    localparam logic signed [25:0] CoefGu = 26'sd5638;
    localparam logic signed [25:0] CoefGv = 26'sd11700;
    localparam logic signed [25:0] CoefBu = 26'sd29032;
    localparam logic signed [25:0] Round  = 26'sd8192;

    // Stage 1: luma and centred chroma
    logic        [8:0] y1_q;
    logic signed [8:0] u1_q, v1_q;

    // Stage 2: products
    logic signed [25:0] yq2_q, pr2_q, pgu2_q, pgv2_q, pb2_q;

    // Stage 3: rounded sums
    logic signed [25:0] sr3_q, sg3_q, sb3_q;

    // Stage 4: output pixel
    logic [23:0] pixel_q;

    // {de, hsync, vsync}, one entry per pipeline stage
    logic [3:0][2:0] sync_q;

    logic signed [25:0] u_ext, v_ext;
    logic [2:0][11:0]   res;
    logic [2:0][7:0]    chan;

    assign u_ext = $signed({{17{u1_q[8]}}, u1_q});
    assign v_ext = $signed({{17{v1_q[8]}}, v1_q});

    // Arithmetic shift right by 14, keeping a 12-bit signed result.
    // The sums never exceed 2^23 in magnitude, so these bits hold the whole value.
    assign res = {sr3_q[25:14], sg3_q[25:14], sb3_q[25:14]};

    logic unused_lsbs;
    assign unused_lsbs = ^{sr3_q[13:0], sg3_q[13:0], sb3_q[13:0]};

`ifdef YCBCR2RGB_CLAMP_EN
    always_comb begin
        chan = '0;
        for (int i = 0; i < 3; i++) begin
            if (res[i][11]) begin
                chan[i] = 8'h00;
            end else if (|res[i][10:8]) begin
                chan[i] = 8'hff;
            end else begin
                chan[i] = res[i][7:0];
            end
        end
    end
`else
    always_comb begin
        chan = '0;
        for (int i = 0; i < 3; i++) begin
            chan[i] = res[i][7:0];
        end
    end

    logic unused_msbs;
    assign unused_msbs = ^{res[2][11:8], res[1][11:8], res[0][11:8]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y1_q    <= '0;
            u1_q    <= '0;
            v1_q    <= '0;
            yq2_q   <= '0;
            pr2_q   <= '0;
            pgu2_q  <= '0;
            pgv2_q  <= '0;
            pb2_q   <= '0;
            sr3_q   <= '0;
            sg3_q   <= '0;
            sb3_q   <= '0;
            pixel_q <= '0;
            sync_q  <= '0;
        end else begin
            // S1
            y1_q   <= {1'b0, pixel_in[23:16]};
            u1_q   <= $signed({1'b0, pixel_in[15:8]}) - 9'sd128;
            v1_q   <= $signed({1'b0, pixel_in[7:0]}) - 9'sd128;
            // S2
            yq2_q  <= $signed({3'b000, y1_q, 14'b0});
            pr2_q  <= CoefRv * v_ext;
            pgu2_q <= CoefGu * u_ext;
            pgv2_q <= CoefGv * v_ext;
            pb2_q  <= CoefBu * u_ext;
            // S3
            sr3_q  <= yq2_q + pr2_q + Round;
            sg3_q  <= yq2_q - pgu2_q - pgv2_q + Round;
            sb3_q  <= yq2_q + pb2_q + Round;
            // S4: gate with the de that enters the last stage alongside this pixel
            pixel_q <= sync_q[2][2] ? {chan[2], chan[1], chan[0]} : 24'h000000;
            sync_q  <= {sync_q[2:0], {de_in, hsync_in, vsync_in}};
        end
    end

    assign de_out    = sync_q[3][2];
    assign hsync_out = sync_q[3][1];
    assign vsync_out = sync_q[3][0];
    assign pixel_out = pixel_q;

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Directed self-checking bench for ycbcr2rgb. It runs in either build;
// the expected values follow YCBCR2RGB_CLAMP_EN.

module tb_ycbcr2rgb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        de_in = 1'b0;
    logic [23:0] pixel_in = '0;
    logic        hsync_out, vsync_out, de_out;
    logic [23:0] pixel_out;

    int checks = 0;
    int errors = 0;

    // Hand-computed vectors: grey, red round-trip, high overflow, low underflow
    logic [23:0] vin  [4];
    logic [23:0] vexp [4];

    // Expected {hsync, vsync, de, pixel} for each driven cycle since reset release
    logic [26:0] exp_q [0:127];
    int          cnt = 0;

    ycbcr2rgb dut (
        .clk       (clk),
        .rst       (rst),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .de_in     (de_in),
        .pixel_in  (pixel_in),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .de_out    (de_out),
        .pixel_out (pixel_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle.
    // After the edge, check the outputs against the input driven 3 calls earlier;
    // that input has now been through its 4th rising edge.
    task automatic drive(input logic hs, input logic vs, input logic de, input int idx);
        logic [26:0] e;
        hsync_in = hs;
        vsync_in = vs;
        de_in    = de;
        pixel_in = vin[idx];
        exp_q[cnt] = {hs, vs, de, (de ? vexp[idx] : 24'h000000)};
        @(posedge clk);
        #1;
        e = (cnt >= 3) ? exp_q[cnt - 3] : 27'd0;
        check("hsync_out", {31'd0, hsync_out}, {31'd0, e[26]});
        check("vsync_out", {31'd0, vsync_out}, {31'd0, e[25]});
        check("de_out",    {31'd0, de_out},    {31'd0, e[24]});
        check("pixel_out", {8'd0, pixel_out},  {8'd0, e[23:0]});
        cnt++;
    endtask

    initial begin
        vin[0] = 24'h808080;                  vexp[0] = 24'h808080;
        vin[1] = {8'd76, 8'd85, 8'd255};      vexp[1] = {8'd254, 8'd0, 8'd0};
        vin[2] = {8'd255, 8'd128, 8'd255};
        vin[3] = {8'd0, 8'd0, 8'd0};
`ifdef YCBCR2RGB_CLAMP_EN
        vexp[2] = {8'd255, 8'd164, 8'd255};
        vexp[3] = {8'd0, 8'd135, 8'd0};
`else
        vexp[2] = {8'd177, 8'd164, 8'd255};
        vexp[3] = {8'd77, 8'd135, 8'd29};
`endif

        // Outputs are held at zero throughout reset
        de_in    = 1'b1;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        pixel_in = 24'h808080;
        repeat (2) @(posedge clk);
        #1;
        check("rst_de",    {31'd0, de_out},    32'd0);
        check("rst_hsync", {31'd0, hsync_out}, 32'd0);
        check("rst_vsync", {31'd0, vsync_out}, 32'd0);
        check("rst_pixel", {8'd0, pixel_out},  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Each vector with de=1, separated by de=0 cycles that carry a pixel to be gated
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, i);
            drive(1'b0, 1'b0, 1'b0, 0);
        end
        // Back-to-back vectors
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, i);
        // Distinct sync patterns: de 3 cycles, hsync 2 cycles, vsync 1 cycle
        drive(1'b0, 1'b0, 1'b1, 1);
        drive(1'b1, 1'b0, 1'b1, 2);
        drive(1'b1, 1'b1, 1'b1, 3);
        drive(1'b0, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 2);
        // de toggling every cycle
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, i[0] ? 1'b0 : 1'b1, (i + 1) % 4);
        // Flush
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 0);

        // Reset mid-line: asserting between edges clears the outputs at once
        drive(1'b1, 1'b1, 1'b1, 0);
        drive(1'b1, 1'b1, 1'b1, 1);
        drive(1'b1, 1'b1, 1'b1, 2);
        drive(1'b1, 1'b1, 1'b1, 0);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_de",    {31'd0, de_out},    32'd0);
        check("midrst_hsync", {31'd0, hsync_out}, 32'd0);
        check("midrst_vsync", {31'd0, vsync_out}, 32'd0);
        check("midrst_pixel", {8'd0, pixel_out},  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        // Nothing in flight survives reset; the first pixel appears on the 4th call
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, i);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
